// File: rtl/nbit_sum_latch_uart_if.sv
// rtl/nbit_sum_latch_uart_if.sv - operand, strobe and UART signal bundle for nbit_sum_latch_uart
interface nbit_sum_latch_uart_if #(
    parameter int WIDTH = 4
);
    logic             save_a_n;
    logic             save_b_n;
    logic [WIDTH-1:0] data_input;
    logic             uart_tx_en;
    logic [WIDTH:0]   sum_out;
    logic             uart_txd;
    logic             uartbusy;

    modport master (
        output save_a_n, save_b_n, data_input, uart_tx_en,
        input  sum_out, uart_txd, uartbusy
    );

    modport slave (
        input  save_a_n, save_b_n, data_input, uart_tx_en,
        output sum_out, uart_txd, uartbusy
    );
endinterface

// File: rtl/nbit_sum_latch_uart.sv
// rtl/nbit_sum_latch_uart.sv - latched A+B adder with UART transmit of the sum (parity: SUMLATCH_PARITY_EN)
module nbit_sum_latch_uart #(
    parameter int WIDTH   = 4,
    parameter int CLK_DIV = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    nbit_sum_latch_uart_if.slave bus
);
    // number of bytes needed to carry the WIDTH+1 bit sum
    localparam int NB     = (WIDTH + 8) / 8;
    localparam int NBITS  = NB * 8;
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [1:0]       BYTE_LAST = 2'(NB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SUMLATCH_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   r_sum;
    logic [NBITS-1:0] r_shift;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_bit;
    logic [1:0]       r_byte;
    logic             r_tx_en_d;
    logic             w_tx_rise;
    logic             w_bit_end;
    logic             w_txd;
`ifdef SUMLATCH_PARITY_EN
    logic             r_par;
`endif

    assign w_tx_rise    = bus.uart_tx_en & ~r_tx_en_d;
    assign w_bit_end    = (r_div == DIV_LAST);
    assign bus.sum_out  = r_sum;
    assign bus.uart_txd = w_txd;
    assign bus.uartbusy = (r_state != S_IDLE);

    // state register; reset returns straight to IDLE, abandoning any frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next-state and line level; requests are only honoured from IDLE
    always_comb begin
        w_next_state = r_state;
        w_txd        = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_tx_rise) w_next_state = S_START;
            end
            S_START: begin
                w_txd = 1'b0;
                if (w_bit_end) w_next_state = S_DATA;
            end
            S_DATA: begin
                w_txd = r_shift[0];
`ifdef SUMLATCH_PARITY_EN
                if (w_bit_end && r_bit == 3'd7) w_next_state = S_PARITY;
`else
                if (w_bit_end && r_bit == 3'd7) w_next_state = S_STOP;
`endif
            end
`ifdef SUMLATCH_PARITY_EN
            S_PARITY: begin
                w_txd = r_par;
                if (w_bit_end) w_next_state = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_bit_end) w_next_state = (r_byte == BYTE_LAST) ? S_IDLE : S_START;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // operand latches, registered sum, and the frame shifter/counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            r_shift   <= '0;
            r_div     <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_tx_en_d <= 1'b0;
        end else begin
            r_tx_en_d <= bus.uart_tx_en;
            if (!bus.save_a_n) r_a <= bus.data_input;
            if (!bus.save_b_n) r_b <= bus.data_input;
            r_sum <= {1'b0, r_a} + {1'b0, r_b};
            if (r_state == S_IDLE) begin
                r_div  <= '0;
                r_bit  <= '0;
                r_byte <= '0;
                // snapshot: the shifter walks all bytes LSB first as one stream
                if (w_tx_rise) r_shift <= NBITS'(r_sum);
            end else begin
                r_div <= w_bit_end ? '0 : r_div + 1'b1;
                if (w_bit_end && r_state == S_DATA) begin
                    r_shift <= r_shift >> 1;
                    r_bit   <= r_bit + 1'b1;
                end
                if (w_bit_end && r_state == S_STOP) r_byte <= r_byte + 1'b1;
            end
        end
    end

`ifdef SUMLATCH_PARITY_EN
    // running even parity of the byte currently on the line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_par <= 1'b0;
        end else if (r_state == S_START) begin
            r_par <= 1'b0;
        end else if (r_state == S_DATA && w_bit_end) begin
            r_par <= r_par ^ r_shift[0];
        end
    end
`endif
endmodule

// File: tb/tb_nbit_sum_latch_uart.sv
// tb/tb_nbit_sum_latch_uart.sv - self-checking bench for nbit_sum_latch_uart (WIDTH 4 and 12 side by side)
module tb_nbit_sum_latch_uart;
    localparam int CLK_DIV = 4;
`ifdef SUMLATCH_PARITY_EN
    localparam int BPB = 11;
`else
    localparam int BPB = 10;
`endif
    localparam int LEN4  = 1 * BPB * CLK_DIV;
    localparam int LEN12 = 2 * BPB * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        save_a_n = 1'b1;
    logic        save_b_n = 1'b1;
    logic        tx_en = 1'b0;
    logic [11:0] din = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int a4 = 0, b4 = 0, a12 = 0, b12 = 0;

    always #5 clk = ~clk;

    nbit_sum_latch_uart_if #(.WIDTH(4))  if4 ();
    nbit_sum_latch_uart_if #(.WIDTH(12)) if12 ();

    assign if4.save_a_n    = save_a_n;
    assign if4.save_b_n    = save_b_n;
    assign if4.data_input  = din[3:0];
    assign if4.uart_tx_en  = tx_en;
    assign if12.save_a_n   = save_a_n;
    assign if12.save_b_n   = save_b_n;
    assign if12.data_input = din;
    assign if12.uart_tx_en = tx_en;

    nbit_sum_latch_uart #(.WIDTH(4), .CLK_DIV(CLK_DIV)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(if4.slave)
    );
    nbit_sum_latch_uart #(.WIDTH(12), .CLK_DIV(CLK_DIV)) dut12 (
        .clk(clk), .reset_n(reset_n), .bus(if12.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // line level expected cyc cycles after the frame is accepted
    function automatic bit exp_txd(input int sum, input int nb, input int cyc);
        int bitpos, byten, k, byteval;
        bitpos  = cyc / CLK_DIV;
        byten   = bitpos / BPB;
        k       = bitpos % BPB;
        if (byten >= nb) return 1'b1;
        byteval = (sum >> (8 * byten)) & 255;
        if (k == 0) return 1'b0;
        if (k <= 8) return bit'((byteval >> (k - 1)) & 1);
        if (BPB == 11 && k == 9) return bit'($countones(byteval) & 1);
        return 1'b1;
    endfunction

    task automatic load(input bit sa, input bit sb, input logic [11:0] d);
        int old4, old12;
        old4  = a4 + b4;
        old12 = a12 + b12;
        save_a_n = ~sa;
        save_b_n = ~sb;
        din      = d;
        @(negedge clk);
        save_a_n = 1'b1;
        save_b_n = 1'b1;
        if (sa) begin a4 = int'(d[3:0]); a12 = int'(d); end
        if (sb) begin b4 = int'(d[3:0]); b12 = int'(d); end
        check("sum4_before_update", 32'(if4.sum_out), 32'(old4));
        check("sum12_before_update", 32'(if12.sum_out), 32'(old12));
        @(negedge clk);
        check("sum4", 32'(if4.sum_out), 32'(a4 + b4));
        check("sum12", 32'(if12.sum_out), 32'(a12 + b12));
    endtask

    // request a frame and follow both lines cycle by cycle through idle tail
    task automatic run_frame(input string tag, input int disturb, input bit hold);
        int s4, s12;
        s4  = a4 + b4;
        s12 = a12 + b12;
        tx_en = 1'b1;
        for (int i = 0; i < LEN12 + 12; i++) begin
            @(negedge clk);
            if (i == 0 && !hold) tx_en = 1'b0;
            check({tag, "_txd4"},   32'(if4.uart_txd),  32'(exp_txd(s4, 1, i)));
            check({tag, "_busy4"},  32'(if4.uartbusy),  32'(i < LEN4));
            check({tag, "_txd12"},  32'(if12.uart_txd), 32'(exp_txd(s12, 2, i)));
            check({tag, "_busy12"}, 32'(if12.uartbusy), 32'(i < LEN12));
            if (disturb >= 0 && i == disturb) begin
                save_a_n = 1'b0;
                din      = '0;
                tx_en    = 1'b1;
            end
            if (disturb >= 0 && i == disturb + 1) begin
                save_a_n = 1'b1;
                tx_en    = 1'b0;
                a4       = 0;
                a12      = 0;
            end
        end
        tx_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_txd4", 32'(if4.uart_txd), 32'd1);
        check("rst_busy4", 32'(if4.uartbusy), 32'd0);
        check("rst_sum4", 32'(if4.sum_out), 32'd0);
        check("rst_txd12", 32'(if12.uart_txd), 32'd1);
        check("rst_sum12", 32'(if12.sum_out), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        load(1'b1, 1'b1, 12'd5);
        load(1'b1, 1'b0, 12'h009);
        load(1'b0, 1'b1, 12'h008);
        run_frame("f_0x11", -1, 1'b0);

        load(1'b1, 1'b0, 12'hFFF);
        load(1'b0, 1'b1, 12'h001);
        run_frame("f_carry", -1, 1'b0);

        load(1'b1, 1'b1, 12'hFFF);
        run_frame("f_0x1e", -1, 1'b0);

        run_frame("midload", 20, 1'b0);

        for (int r = 0; r < 4; r++) begin
            bit          sa, sb;
            logic [11:0] d;
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            if (!sa && !sb) sa = 1'b1;
            d = 12'($urandom);
            load(sa, sb, d);
            run_frame("rand", -1, 1'b0);
        end

        tx_en = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        repeat (17) @(negedge clk);
        reset_n = 1'b0;
        #1;
        a4 = 0; b4 = 0; a12 = 0; b12 = 0;
        check("abort_txd4", 32'(if4.uart_txd), 32'd1);
        check("abort_busy4", 32'(if4.uartbusy), 32'd0);
        check("abort_txd12", 32'(if12.uart_txd), 32'd1);
        check("abort_busy12", 32'(if12.uartbusy), 32'd0);
        check("abort_sum12", 32'(if12.sum_out), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("post_abort_txd4", 32'(if4.uart_txd), 32'd1);
            check("post_abort_busy12", 32'(if12.uartbusy), 32'd0);
        end

        reset_n = 1'b0;
        tx_en   = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        run_frame("held_through_reset", -1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
